// File: rtl/fetch_ctrl_pkg.sv
// Shared types and defaults for the instruction-fetch sequencer.
// Latency: none. This file holds declarations only.
// Backpressure: none. This file holds declarations only.
// Contents: the fetch_state_e state encoding, the default address width and the boot address.
package fetch_ctrl_pkg;

   localparam int unsigned DEF_ADDR_WIDTH = 32;
   localparam int unsigned INSTR_WIDTH    = 32;
   // Start of .text in the core's memory map.
   localparam logic [31:0] DEF_BOOT_ADDR  = 32'h0001_0074;

   typedef enum logic [1:0] {
      FETCH = 2'd0,  // request outstanding to memory, waiting for grant
      WAIT  = 2'd1,  // granted, waiting for response data
      OUT   = 2'd2,  // instruction presented to decoder
      DROP  = 2'd3   // draining the response of a cancelled request
   } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Bundles the instruction-memory and decoder-side signals of the fetch sequencer.
// Latency: none. This file contains wiring only.
// Backpressure: memory stalls through gnt and rvalid, and the decoder stalls through ready.
// Ports: instr_req/addr/gnt/rvalid/rdata (memory), redirect/redirect_addr (execute),
//        instr_valid/instr/instr_pc/ready (decoder). master = fetch_ctrl, slave = environment.
interface fetch_ctrl_if
   import fetch_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
);
   logic                   instr_req_o;
   logic [ADDR_WIDTH-1:0]  instr_addr_o;
   logic                   instr_gnt_i;
   logic                   instr_rvalid_i;
   logic [INSTR_WIDTH-1:0] instr_rdata_i;
   logic                   redirect_i;
   logic [ADDR_WIDTH-1:0]  redirect_addr_i;
   logic                   instr_valid_o;
   logic [INSTR_WIDTH-1:0] instr_o;
   logic [ADDR_WIDTH-1:0]  instr_pc_o;
   logic                   instr_ready_i;

   modport master (
      output instr_req_o, instr_addr_o, instr_valid_o, instr_o, instr_pc_o,
      input  instr_gnt_i, instr_rvalid_i, instr_rdata_i, redirect_i, redirect_addr_i,
             instr_ready_i
   );

   modport slave (
      input  instr_req_o, instr_addr_o, instr_valid_o, instr_o, instr_pc_o,
      output instr_gnt_i, instr_rvalid_i, instr_rdata_i, redirect_i, redirect_addr_i,
             instr_ready_i
   );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer that owns the PC and allows one outstanding memory request.
// Latency: the first instruction is valid 2 cycles after reset release. In the best case it issues 1 instruction every 3 cycles.
// Backpressure: it holds req and addr until gnt. It holds valid and data until ready. A redirect cancels in-flight work.
// Ports: clk, rst_n (synchronous, active-low), bus (fetch_ctrl_if.master: memory + redirect + decoder).
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = ADDR_WIDTH'(DEF_BOOT_ADDR)
) (
   input logic          clk,
   input logic          rst_n,
   fetch_ctrl_if.master bus
);

   localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

   fetch_state_e           state_q, state_d;
   logic                   run_q;
   logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
   logic [INSTR_WIDTH-1:0] instr_q, instr_d;
   logic [ADDR_WIDTH-1:0]  instr_pc_q, instr_pc_d;
   logic [ADDR_WIDTH-1:0]  redirect_pc;
   logic                   unused_redirect_low;

   // Targets are word aligned. The low two bits of the redirect address are dropped.
   assign redirect_pc         = {bus.redirect_addr_i[ADDR_WIDTH-1:2], 2'b00};
   assign unused_redirect_low = ^bus.redirect_addr_i[1:0];

   // State, PC and the presented instruction update together.
   // run_q is clear during reset and for the reset-release edge. This keeps req low
   // while rst_n is low, without any combinational path from rst_n to an output.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= FETCH;
         run_q      <= 1'b0;
         pc_q       <= BOOT_ADDR;
         instr_q    <= '0;
         instr_pc_q <= '0;
      end else begin
         state_q    <= state_d;
         run_q      <= 1'b1;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         instr_pc_q <= instr_pc_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;

      unique case (state_q)
         FETCH: begin
            // A grant that arrives together with a redirect is for the stale address.
            // Its response must still drain, so the FSM goes to DROP.
            if (run_q && bus.instr_gnt_i) begin
               state_d = bus.redirect_i ? DROP : WAIT;
            end
         end
         WAIT: begin
            if (bus.instr_rvalid_i) begin
               if (bus.redirect_i) begin
                  state_d = FETCH;
               end else begin
                  instr_d    = bus.instr_rdata_i;
                  instr_pc_d = pc_q;
                  state_d    = OUT;
               end
            end else if (bus.redirect_i) begin
               state_d = DROP;
            end
         end
         OUT: begin
            if (bus.redirect_i) begin
               state_d = FETCH;
            end else if (bus.instr_ready_i) begin
               pc_d    = pc_q + PC_STEP;
               state_d = FETCH;
            end
         end
         DROP: begin
            if (bus.instr_rvalid_i) begin
               state_d = FETCH;
            end
         end
         default: state_d = FETCH;
      endcase

      // A redirect overrides the sequential increment in every state.
      if (bus.redirect_i) begin
         pc_d = redirect_pc;
      end
   end

   // Output decode. Every output depends only on registered state.
   always_comb begin
      bus.instr_req_o   = run_q && (state_q == FETCH);
      bus.instr_addr_o  = pc_q;
      bus.instr_valid_o = (state_q == OUT);
      bus.instr_o       = instr_q;
      bus.instr_pc_o    = instr_pc_q;
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl. It contains a cycle-stepped memory model and a PC-sequence reference model.
// Latency: not applicable.
// Backpressure: it varies the memory grant and response delays and the decoder ready signal.
module tb_fetch_ctrl;
   import fetch_ctrl_pkg::*;

   localparam int unsigned AW   = DEF_ADDR_WIDTH;
   localparam logic [31:0] BOOT = DEF_BOOT_ADDR;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fetch_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

   fetch_ctrl #(.ADDR_WIDTH(AW), .BOOT_ADDR(BOOT)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int checks = 0;
   int errors = 0;

   // Memory model knobs and state.
   int          gnt_lat  = 0;
   bit          gnt_rand = 1'b0;
   int          rsp_min  = 1;
   int          rsp_max  = 1;
   bit          stray_en = 1'b0;
   bit          m_out    = 1'b0;
   int          m_cnt    = 0;
   int          m_wait   = 0;
   logic [31:0] m_addr   = '0;
   bit          prev_req = 1'b0;
   bit          prev_gnt = 1'b0;
   bit          prev_rv  = 1'b0;
   logic [31:0] prev_addr = '0;
   int          n_grants = 0;

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   // Advance one clock. Inputs for the new cycle are driven 1 time unit after the edge.
   task automatic step();
      bit rv_real;
      bit g;
      @(posedge clk);
      #1;
      if (prev_rv) m_out = 1'b0;
      if (prev_req && prev_gnt) begin
         m_out  = 1'b1;
         m_addr = prev_addr;
         m_cnt  = int'($urandom_range(rsp_max, rsp_min)) - 1;
         n_grants++;
      end
      rv_real = 1'b0;
      if (m_out) begin
         if (m_cnt == 0) rv_real = 1'b1;
         else m_cnt--;
      end
      bus.instr_rvalid_i = rv_real;
      bus.instr_rdata_i  = rv_real ? mem_data(m_addr) : $urandom();
      if (!rv_real && !m_out && stray_en && $urandom_range(0, 3) == 0) bus.instr_rvalid_i = 1'b1;
      if (bus.instr_req_o === 1'b1 && !m_out) begin
         g      = gnt_rand ? ($urandom_range(0, 2) == 0) : (m_wait >= gnt_lat);
         m_wait = g ? 0 : m_wait + 1;
      end else begin
         m_wait = 0;
         g      = stray_en && (bus.instr_req_o !== 1'b1) && ($urandom_range(0, 3) == 0);
      end
      bus.instr_gnt_i = g;
      prev_req  = (bus.instr_req_o === 1'b1);
      prev_gnt  = g;
      prev_addr = bus.instr_addr_o;
      prev_rv   = rv_real;
   endtask

   // Hold reset for three edges, then release it. On return the first cycle after release is current.
   task automatic do_reset();
      rst_n               = 1'b0;
      stray_en            = 1'b0;
      bus.instr_gnt_i     = 1'b0;
      bus.instr_rvalid_i  = 1'b0;
      bus.instr_ready_i   = 1'b0;
      bus.redirect_i      = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      m_out = 1'b0; m_wait = 0; prev_req = 1'b0; prev_gnt = 1'b0; prev_rv = 1'b0; n_grants = 0;
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      checks++; if (bus.instr_req_o !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", bus.instr_req_o); end
      checks++; if (bus.instr_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", bus.instr_valid_o); end
      checks++; if (bus.instr_o !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h want 0", bus.instr_o); end
      checks++; if (bus.instr_pc_o !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h want 0", bus.instr_pc_o); end
      gnt_lat = 5; gnt_rand = 1'b0; rsp_min = 1; rsp_max = 1;
      do_reset();
      checks++; if (bus.instr_req_o !== 1'b1) begin errors++; $display("FAIL rel_req: got %b want 1", bus.instr_req_o); end
      checks++; if (bus.instr_addr_o !== BOOT) begin errors++; $display("FAIL rel_addr: got %h want %h", bus.instr_addr_o, BOOT); end
   endtask

   task automatic test_best_case();
      int k;
      logic [31:0] e;
      gnt_lat = 0; gnt_rand = 1'b0; rsp_min = 1; rsp_max = 1;
      do_reset();
      bus.instr_ready_i = 1'b1;
      k = 0;
      for (int c = 0; c < 12; c++) begin
         if (bus.instr_valid_o === 1'b1) begin
            e = BOOT + 32'(4 * k);
            checks++; if (bus.instr_pc_o !== e) begin errors++; $display("FAIL bb_pc: got %h want %h", bus.instr_pc_o, e); end
            checks++; if (bus.instr_o !== mem_data(e)) begin errors++; $display("FAIL bb_instr: got %h want %h", bus.instr_o, mem_data(e)); end
            checks++; if (c != 2 + 3 * k) begin errors++; $display("FAIL bb_cycle: got %0d want %0d", c, 2 + 3 * k); end
            k++;
         end
         step();
      end
      checks++; if (k != 4) begin errors++; $display("FAIL bb_count: got %0d want 4", k); end
   endtask

   task automatic test_gnt_delay();
      gnt_lat = 3; gnt_rand = 1'b0; rsp_min = 1; rsp_max = 1;
      do_reset();
      bus.instr_ready_i = 1'b1;
      for (int c = 0; c < 4; c++) begin
         checks++; if (bus.instr_req_o !== 1'b1) begin errors++; $display("FAIL gd_req c%0d: got %b want 1", c, bus.instr_req_o); end
         checks++; if (bus.instr_addr_o !== BOOT) begin errors++; $display("FAIL gd_addr c%0d: got %h want %h", c, bus.instr_addr_o, BOOT); end
         step();
      end
      checks++; if (bus.instr_req_o !== 1'b0) begin errors++; $display("FAIL gd_wait_req: got %b want 0", bus.instr_req_o); end
      step();
      checks++; if (bus.instr_valid_o !== 1'b1 || bus.instr_pc_o !== BOOT) begin errors++; $display("FAIL gd_out: got valid %b pc %h want 1 %h", bus.instr_valid_o, bus.instr_pc_o, BOOT); end
      checks++; if (n_grants != 1) begin errors++; $display("FAIL gd_grants: got %0d want 1", n_grants); end
   endtask

   task automatic test_ready_stall();
      int w;
      logic [31:0] hi, hp;
      gnt_lat = 0; gnt_rand = 1'b0; rsp_min = 1; rsp_max = 1;
      do_reset();
      w = 0;
      while (bus.instr_valid_o !== 1'b1 && w < 10) begin step(); w++; end
      checks++; if (bus.instr_valid_o !== 1'b1) begin errors++; $display("FAIL rs_timeout: got valid %b want 1", bus.instr_valid_o); end
      hi = bus.instr_o; hp = bus.instr_pc_o;
      checks++; if (hp !== BOOT) begin errors++; $display("FAIL rs_pc: got %h want %h", hp, BOOT); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (bus.instr_valid_o !== 1'b1) begin errors++; $display("FAIL rs_valid %0d: got %b want 1", i, bus.instr_valid_o); end
         checks++; if (bus.instr_o !== hi || bus.instr_pc_o !== hp) begin errors++; $display("FAIL rs_stable %0d: got %h/%h want %h/%h", i, bus.instr_o, bus.instr_pc_o, hi, hp); end
         checks++; if (bus.instr_req_o !== 1'b0) begin errors++; $display("FAIL rs_noreq %0d: got %b want 0", i, bus.instr_req_o); end
         step();
      end
      bus.instr_ready_i = 1'b1;
      step();
      bus.instr_ready_i = 1'b0;
      checks++; if (bus.instr_valid_o !== 1'b0) begin errors++; $display("FAIL rs_drop_valid: got %b want 0", bus.instr_valid_o); end
      checks++; if (bus.instr_req_o !== 1'b1 || bus.instr_addr_o !== BOOT + 32'd4) begin errors++; $display("FAIL rs_next: got req %b addr %h want 1 %h", bus.instr_req_o, bus.instr_addr_o, BOOT + 32'd4); end
   endtask

   task automatic test_redirect_wait();
      int w;
      gnt_lat = 0; gnt_rand = 1'b0; rsp_min = 3; rsp_max = 3;
      do_reset();
      bus.instr_ready_i = 1'b1;
      step();
      checks++; if (bus.instr_req_o !== 1'b0 || m_out !== 1'b1) begin errors++; $display("FAIL rw_in_wait: got req %b out %b want 0 1", bus.instr_req_o, m_out); end
      bus.redirect_i = 1'b1; bus.redirect_addr_i = 32'h0002_0003;
      step();
      bus.redirect_i = 1'b0;
      for (int c = 2; c < 4; c++) begin
         checks++; if (bus.instr_req_o !== 1'b0 || bus.instr_valid_o !== 1'b0) begin errors++; $display("FAIL rw_drop c%0d: got req %b valid %b want 0 0", c, bus.instr_req_o, bus.instr_valid_o); end
         step();
      end
      rsp_min = 1; rsp_max = 1;
      checks++; if (bus.instr_req_o !== 1'b1 || bus.instr_addr_o !== 32'h0002_0000) begin errors++; $display("FAIL rw_refetch: got req %b addr %h want 1 00020000", bus.instr_req_o, bus.instr_addr_o); end
      w = 0;
      while (bus.instr_valid_o !== 1'b1 && w < 10) begin step(); w++; end
      checks++; if (bus.instr_valid_o !== 1'b1 || bus.instr_pc_o !== 32'h0002_0000) begin errors++; $display("FAIL rw_first: got valid %b pc %h want 1 00020000", bus.instr_valid_o, bus.instr_pc_o); end
      checks++; if (bus.instr_o !== mem_data(32'h0002_0000)) begin errors++; $display("FAIL rw_data: got %h want %h", bus.instr_o, mem_data(32'h0002_0000)); end
   endtask

   task automatic test_redirect_gnt();
      int w;
      gnt_lat = 0; gnt_rand = 1'b0; rsp_min = 2; rsp_max = 2;
      do_reset();
      bus.instr_ready_i = 1'b1;
      bus.redirect_i = 1'b1; bus.redirect_addr_i = 32'h0003_0000;
      step();
      bus.redirect_i = 1'b0;
      checks++; if (bus.instr_req_o !== 1'b0 || bus.instr_valid_o !== 1'b0) begin errors++; $display("FAIL rg_drop: got req %b valid %b want 0 0", bus.instr_req_o, bus.instr_valid_o); end
      step();
      checks++; if (bus.instr_req_o !== 1'b0 || bus.instr_rvalid_i !== 1'b1) begin errors++; $display("FAIL rg_drain: got req %b rvalid %b want 0 1", bus.instr_req_o, bus.instr_rvalid_i); end
      step();
      checks++; if (bus.instr_req_o !== 1'b1 || bus.instr_addr_o !== 32'h0003_0000) begin errors++; $display("FAIL rg_refetch: got req %b addr %h want 1 00030000", bus.instr_req_o, bus.instr_addr_o); end
      step();
      checks++; if (bus.instr_valid_o !== 1'b0 || bus.instr_req_o !== 1'b0) begin errors++; $display("FAIL rg_wait: got valid %b req %b want 0 0", bus.instr_valid_o, bus.instr_req_o); end
      step();
      // The response for 0x30000 arrives in this cycle, together with a second redirect.
      bus.redirect_i = 1'b1; bus.redirect_addr_i = 32'h0004_0008;
      step();
      bus.redirect_i = 1'b0;
      rsp_min = 1; rsp_max = 1;
      checks++; if (bus.instr_valid_o !== 1'b0) begin errors++; $display("FAIL rg_rv_discard: got valid %b want 0", bus.instr_valid_o); end
      checks++; if (bus.instr_req_o !== 1'b1 || bus.instr_addr_o !== 32'h0004_0008) begin errors++; $display("FAIL rg_rv_refetch: got req %b addr %h want 1 00040008", bus.instr_req_o, bus.instr_addr_o); end
      w = 0;
      while (bus.instr_valid_o !== 1'b1 && w < 10) begin step(); w++; end
      checks++; if (bus.instr_valid_o !== 1'b1 || bus.instr_pc_o !== 32'h0004_0008) begin errors++; $display("FAIL rg_first: got valid %b pc %h want 1 00040008", bus.instr_valid_o, bus.instr_pc_o); end
   endtask

   task automatic test_wrap();
      int w;
      gnt_lat = 1; gnt_rand = 1'b0; rsp_min = 1; rsp_max = 1;
      do_reset();
      bus.instr_ready_i = 1'b1;
      bus.redirect_i = 1'b1; bus.redirect_addr_i = 32'hFFFF_FFFE;
      step();
      bus.redirect_i = 1'b0;
      checks++; if (bus.instr_req_o !== 1'b1 || bus.instr_addr_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_addr: got req %b addr %h want 1 fffffffc", bus.instr_req_o, bus.instr_addr_o); end
      w = 0;
      while (bus.instr_valid_o !== 1'b1 && w < 10) begin step(); w++; end
      checks++; if (bus.instr_valid_o !== 1'b1 || bus.instr_pc_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_out: got valid %b pc %h want 1 fffffffc", bus.instr_valid_o, bus.instr_pc_o); end
      step();
      checks++; if (bus.instr_req_o !== 1'b1 || bus.instr_addr_o !== 32'h0) begin errors++; $display("FAIL wr_next: got req %b addr %h want 1 00000000", bus.instr_req_o, bus.instr_addr_o); end
   endtask

   task automatic test_mid_reset();
      int w;
      gnt_lat = 0; gnt_rand = 1'b0; rsp_min = 4; rsp_max = 4;
      do_reset();
      bus.instr_ready_i = 1'b1;
      step();
      checks++; if (bus.instr_req_o !== 1'b0) begin errors++; $display("FAIL mr_wait: got req %b want 0", bus.instr_req_o); end
      rsp_min = 1; rsp_max = 1;
      do_reset();
      bus.instr_ready_i = 1'b1;
      checks++; if (bus.instr_req_o !== 1'b1 || bus.instr_addr_o !== BOOT || bus.instr_valid_o !== 1'b0) begin errors++; $display("FAIL mr_restart: got req %b addr %h valid %b want 1 %h 0", bus.instr_req_o, bus.instr_addr_o, bus.instr_valid_o, BOOT); end
      w = 0;
      while (bus.instr_valid_o !== 1'b1 && w < 10) begin step(); w++; end
      checks++; if (bus.instr_valid_o !== 1'b1 || bus.instr_pc_o !== BOOT) begin errors++; $display("FAIL mr_first: got valid %b pc %h want 1 %h", bus.instr_valid_o, bus.instr_pc_o, BOOT); end
   endtask

   // Reference model: the next instruction the decoder sees must be at exp_pc.
   // exp_pc becomes the aligned target after a redirect, otherwise the accepted PC plus 4.
   task automatic test_random();
      logic [31:0] exp_pc, tgt;
      bit rdy, redir;
      int accepts;
      gnt_lat = 0; gnt_rand = 1'b1; rsp_min = 1; rsp_max = 3;
      do_reset();
      stray_en = 1'b1;
      exp_pc   = BOOT;
      accepts  = 0;
      for (int c = 0; c < 4000; c++) begin
         if (bus.instr_req_o === 1'b1) begin
            checks++; if (bus.instr_addr_o !== exp_pc) begin errors++; $display("FAIL rnd_addr c%0d: got %h want %h", c, bus.instr_addr_o, exp_pc); end
            checks++; if (m_out !== 1'b0) begin errors++; $display("FAIL rnd_outstanding c%0d: got req with pending response, want none", c); end
         end
         if (bus.instr_valid_o === 1'b1) begin
            checks++; if (bus.instr_pc_o !== exp_pc) begin errors++; $display("FAIL rnd_pc c%0d: got %h want %h", c, bus.instr_pc_o, exp_pc); end
            checks++; if (bus.instr_o !== mem_data(exp_pc)) begin errors++; $display("FAIL rnd_instr c%0d: got %h want %h", c, bus.instr_o, mem_data(exp_pc)); end
         end
         rdy   = ($urandom_range(0, 2) != 0);
         redir = ($urandom_range(0, 15) == 0);
         tgt   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFD : $urandom();
         bus.instr_ready_i   = rdy;
         bus.redirect_i      = redir;
         bus.redirect_addr_i = tgt;
         if (bus.instr_valid_o === 1'b1 && rdy) begin
            accepts++;
            exp_pc = exp_pc + 32'd4;
         end
         if (redir) exp_pc = {tgt[31:2], 2'b00};
         step();
      end
      bus.redirect_i = 1'b0;
      bus.instr_ready_i = 1'b0;
      checks++; if (accepts < 200) begin errors++; $display("FAIL rnd_progress: got %0d accepts want at least 200", accepts); end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.instr_gnt_i     = 1'b0;
      bus.instr_rvalid_i  = 1'b0;
      bus.instr_rdata_i   = '0;
      bus.redirect_i      = 1'b0;
      bus.redirect_addr_i = '0;
      bus.instr_ready_i   = 1'b0;
      test_reset();
      test_best_case();
      test_gnt_delay();
      test_ready_stall();
      test_redirect_wait();
      test_redirect_gnt();
      test_wrap();
      test_mid_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer for the single-issue RV32 core: owns the program counter, drives the instruction-memory request/grant/response handshake with one outstanding request, and presents fetched instructions to the decoder with a valid/ready handshake. Redirects from the execute stage (taken branch, jump) retarget the PC and discard any in-flight or buffered instruction. Sits between instruction memory and the decoder, replacing free-running PC increment with a stall-aware sequence.

## Interface

- ADDR_WIDTH, 32, instruction address width
- BOOT_ADDR, 32'h0001_0074, PC after reset (start of .text)

- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- instr_req_o  out  1  memory request valid
- instr_addr_o  out  ADDR_WIDTH  request address, word aligned
- instr_gnt_i  in  1  memory accepted request this cycle
- instr_rvalid_i  in  1  response data valid
- instr_rdata_i  in  32  response data
- redirect_i  in  1  execute stage: PC must change (jump or taken branch)
- redirect_addr_i  in  ADDR_WIDTH  redirect target
- instr_valid_o  out  1  instruction available to decoder
- instr_o  out  32  instruction word
- instr_pc_o  out  ADDR_WIDTH  address of instr_o
- instr_ready_i  in  1  decoder accepts instruction

## Operation

- States: FETCH, WAIT, OUT, DROP. Internal pc register.
- FETCH: instr_req_o=1, instr_addr_o=pc. gnt -> WAIT. Address may change before grant (redirect); held stable once granted.
- WAIT: req=0. rvalid -> latch rdata into instr_o, pc into instr_pc_o, go OUT.
- OUT: instr_valid_o=1, instr_o/instr_pc_o stable. valid&ready -> pc <= pc+4, go FETCH.
- DROP: req=0; waits for the response of a cancelled request. rvalid -> data discarded, go FETCH.
- Redirect (any state): pc <= {redirect_addr_i[ADDR_WIDTH-1:2], 2'b00}; low two bits ignored. Redirect wins over the pc+4 increment.
  - FETCH without gnt -> stay FETCH, new address next cycle.
  - FETCH with gnt same cycle -> DROP.
  - WAIT without rvalid -> DROP; with rvalid same cycle -> response discarded, FETCH.
  - OUT -> instr_valid_o drops next cycle, FETCH (even if ready same cycle; instruction not counted as fetched-ahead, decoder handles own accept).
  - DROP -> stay DROP (or FETCH if rvalid same cycle), pc updated.
- pc arithmetic modulo 2^ADDR_WIDTH; 32'hFFFF_FFFC + 4 wraps to 0.
- rvalid outside WAIT/DROP ignored; gnt outside FETCH ignored.

## Timing

- Reset: state FETCH, pc=BOOT_ADDR, instr_valid_o=0, instr_o=0, instr_pc_o=0. instr_req_o=0 while rst_n=0; =1 in first cycle after release with addr BOOT_ADDR.
- req/addr/valid are decoded from registered state/pc: no combinational path from any input to any output.
- Best case (gnt immediately, rvalid next cycle, ready immediately): 3 cycles per instruction; first instruction valid 2 cycles after reset release.
- Redirect seen at edge N: new address on instr_addr_o from cycle N+1 (FETCH case) or after cancelled response drains (DROP).
- Reset mid-transaction: state forced to FETCH; memory must itself abort pending response on reset.

## Structure

- Shared core package: fetch_state_e enum (FETCH, WAIT, OUT, DROP) and BOOT_ADDR default constant, reused by the top-level and bench.
- Single module, no sub-module; pc update and FSM in one sequential process, output decode combinational.

## Test plan

- Reset release, gnt=1 always, rvalid one cycle after gnt, ready=1, rdata=pc -> addresses 0x10074, 0x10078, 0x1007C; instr_pc_o matches instr_o.
- gnt delayed 3 cycles -> instr_addr_o held at 0x10074 with req=1 throughout; single request issued.
- ready=0 for 4 cycles in OUT -> instr_valid_o=1, instr_o stable, no new request; pc advances only after accept.
- Redirect to 0x20003 in WAIT, rvalid 2 cycles later -> that response never reaches instr_valid_o; next request addr 0x20000.
- Redirect to 0x30000 same cycle as gnt -> DROP, cancelled data dropped, next request 0x30000; redirect and rvalid same cycle -> same.
- pc at 0xFFFF_FFFC accepted -> next request addr 0x0000_0000.
